// File: rtl/cla_pkg.sv
// Shared definitions for the word-serial CLA adder/subtractor.
// Holds the control FSM state type, the slice width and the signed
// overflow helper used when the final nibble is written.
package cla_pkg;

  // Control FSM states of the serial sequencer.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the carry-look-ahead slice; one slice pass per nibble.
  localparam int SLICE_W = 4;

  // Two's-complement overflow: both effective operands share a sign and
  // the result sign differs from it. bx_msb is the B sign after the
  // subtract inversion has been applied.
  function automatic logic signed_ovf(input logic a_msb,
                                      input logic bx_msb,
                                      input logic r_msb);
    return (a_msb == bx_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/carry_look_ahead_adder_subtractor.sv
// 4-bit carry-look-ahead adder/subtractor slice.
// Latency: combinational. Backpressure: none (pure datapath).
// Ports: A, B operands; Cin carry-in; control=1 inverts B (subtract);
//        sum = A + (B ^ {4{control}}) + Cin; Cout carry out of bit 3.
module carry_look_ahead_adder_subtractor
  import cla_pkg::*;
(
  input  logic [SLICE_W-1:0] A,
  input  logic [SLICE_W-1:0] B,
  input  logic               Cin,
  input  logic               control,
  output logic [SLICE_W-1:0] sum,
  output logic               Cout
);

  logic [SLICE_W-1:0] bx;
  logic [SLICE_W-1:0] g;
  logic [SLICE_W-1:0] p;
  logic [SLICE_W:0]   c;

  // Subtract is add of the ones' complement; the +1 comes in through Cin.
  assign bx = B ^ {SLICE_W{control}};
  assign g  = A & bx;
  assign p  = A ^ bx;

  // Every carry is a flat two-level expression of g, p and Cin, so no
  // carry ripples through the slice.
  assign c[0] = Cin;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign sum  = p ^ c[SLICE_W-1:0];
  assign Cout = c[SLICE_W];

endmodule

// File: rtl/cla_serial_addsub.sv
// Word-serial WIDTH-bit add/sub through one 4-bit CLA slice, LS nibble first.
// Latency: out_valid rises after edge T+NIBBLES for an accept at edge T.
// Backpressure: result/cout/ovf/out_valid hold while out_ready=0; no new accept until handshake.
// Ports: clk, rst (async, active-high); in_valid/in_ready with a, b, sub, cin;
//        out_valid/out_ready with result, cout (add carry / sub no-borrow), ovf.
module cla_serial_addsub
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int NIBBLES = WIDTH / SLICE_W;
  // A one-nibble word still needs a 1-bit index register.
  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  state_t           state;
  logic [IDXW-1:0]  idx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             sub_q;
  logic             carry_q;
  logic [WIDTH-1:0] result_q;
  logic             ovf_q;
  logic             out_valid_q;

  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b;
  logic [SLICE_W-1:0] slice_sum;
  logic               slice_cout;

  // Nibble selected by the running index feeds the single shared slice.
  assign slice_a = a_q[SLICE_W*idx +: SLICE_W];
  assign slice_b = b_q[SLICE_W*idx +: SLICE_W];

  carry_look_ahead_adder_subtractor u_slice (
    .A       (slice_a),
    .B       (slice_b),
    .Cin     (carry_q),
    .control (sub_q),
    .sum     (slice_sum),
    .Cout    (slice_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sub_q       <= 1'b0;
      carry_q     <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            sub_q <= sub;
            // Subtract runs as A + ~B + 1 - borrow, so the slice sees an
            // inverted borrow-in as its carry-in.
            carry_q <= sub ? ~cin : cin;
            idx     <= '0;
            state   <= RUN;
          end
        end

        RUN: begin
          result_q[SLICE_W*idx +: SLICE_W] <= slice_sum;
          carry_q <= slice_cout;
          if (idx == LAST_IDX) begin
            // Final nibble carries the sign bit, so overflow is resolved
            // here and then held with the rest of the result.
            ovf_q       <= signed_ovf(a_q[WIDTH-1], b_q[WIDTH-1] ^ sub_q,
                                      slice_sum[SLICE_W-1]);
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end

        default: begin
          out_valid_q <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  // carry_q only moves on accept or in RUN, so it doubles as the held
  // carry/no-borrow output through DONE and the following IDLE.
  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign cout      = carry_q;
  assign ovf       = ovf_q;

endmodule
